// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Purpose:
//   Merges ALU and load writebacks onto the single Registers_32 write port.
//   Each requester owns a one-entry holding buffer. Each cycle, one valid
//   buffer is granted. The granted entry is written to the register file on
//   the following cycle through registered RegWrite/WriteReg/WriteRegData.
//   An entry that targets register 0 is consumed without a write.
//
// Configuration:
//   REGFILE_WR_ROUND_ROBIN_EN
//     undefined (default) : fixed priority, the Mem buffer beats the Alu buffer
//     defined             : a 1-bit round-robin pointer favours the requester
//                           that was not granted last
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset_n      in   1   synchronous active-low reset
//   AluValid     in   1   ALU writeback request
//   AluReg       in   5   ALU destination register
//   AluData      in  32   ALU result
//   AluReady     out  1   ALU request accepted this cycle when AluValid=1
//   MemValid     in   1   load writeback request
//   MemReg       in   5   load destination register
//   MemData      in  32   load data
//   MemReady     out  1   load request accepted this cycle when MemValid=1
//   RegWrite     out  1   register-file write enable
//   WriteReg     out  5   register-file write address
//   WriteRegData out 32   register-file write data
//   Idle         out  1   both buffers empty and no write issuing
// -----------------------------------------------------------------------------
module regfile_write_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        AluValid,
    input  logic [4:0]  AluReg,
    input  logic [31:0] AluData,
    output logic        AluReady,
    input  logic        MemValid,
    input  logic [4:0]  MemReg,
    input  logic [31:0] MemData,
    output logic        MemReady,
    output logic        RegWrite,
    output logic [4:0]  WriteReg,
    output logic [31:0] WriteRegData,
    output logic        Idle
);

    // Holding buffers
    logic        alu_vld_q, alu_vld_d;
    logic [4:0]  alu_reg_q, alu_reg_d;
    logic [31:0] alu_data_q, alu_data_d;
    logic        mem_vld_q, mem_vld_d;
    logic [4:0]  mem_reg_q, mem_reg_d;
    logic [31:0] mem_data_q, mem_data_d;

    // Register-file write port
    logic        wr_en_q, wr_en_d;
    logic [4:0]  wr_reg_q, wr_reg_d;
    logic [31:0] wr_data_q, wr_data_d;

    logic        grant_alu_s;
    logic        grant_mem_s;
    logic        alu_fire_s;
    logic        mem_fire_s;
    logic [4:0]  sel_reg_s;
    logic [31:0] sel_data_s;

`ifdef REGFILE_WR_ROUND_ROBIN_EN
    // 1 = Alu has priority on the next contended cycle; 0 = Mem has priority
    logic        rr_alu_pri_q, rr_alu_pri_d;

    // Round-robin grant selection
    always_comb begin
        grant_alu_s = 1'b0;
        grant_mem_s = 1'b0;
        if (alu_vld_q && mem_vld_q) begin
            if (rr_alu_pri_q) begin
                grant_alu_s = 1'b1;
            end else begin
                grant_mem_s = 1'b1;
            end
        end else if (mem_vld_q) begin
            grant_mem_s = 1'b1;
        end else if (alu_vld_q) begin
            grant_alu_s = 1'b1;
        end else begin
            grant_mem_s = 1'b0;
        end
    end

    // The pointer moves on every grant, including grants to register 0
    always_comb begin
        rr_alu_pri_d = rr_alu_pri_q;
        if (grant_mem_s) begin
            rr_alu_pri_d = 1'b1;
        end else if (grant_alu_s) begin
            rr_alu_pri_d = 1'b0;
        end else begin
            rr_alu_pri_d = rr_alu_pri_q;
        end
    end

    // Pointer register; reset points at Mem
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_alu_pri_q <= 1'b0;
        end else begin
            rr_alu_pri_q <= rr_alu_pri_d;
        end
    end
`else
    // Fixed-priority grant selection: Mem beats Alu
    always_comb begin
        grant_alu_s = 1'b0;
        grant_mem_s = 1'b0;
        if (mem_vld_q) begin
            grant_mem_s = 1'b1;
        end else if (alu_vld_q) begin
            grant_alu_s = 1'b1;
        end else begin
            grant_mem_s = 1'b0;
        end
    end
`endif

    // Ready depends only on buffer state and grant, never on the request inputs
    assign AluReady   = reset_n & (~alu_vld_q | grant_alu_s);
    assign MemReady   = reset_n & (~mem_vld_q | grant_mem_s);
    assign alu_fire_s = AluValid & AluReady;
    assign mem_fire_s = MemValid & MemReady;

    assign sel_reg_s  = grant_mem_s ? mem_reg_q  : alu_reg_q;
    assign sel_data_s = grant_mem_s ? mem_data_q : alu_data_q;

    // Buffer next state: a same-edge transfer refills, otherwise a grant empties
    always_comb begin
        alu_vld_d  = alu_vld_q;
        alu_reg_d  = alu_reg_q;
        alu_data_d = alu_data_q;
        mem_vld_d  = mem_vld_q;
        mem_reg_d  = mem_reg_q;
        mem_data_d = mem_data_q;
        if (alu_fire_s) begin
            alu_vld_d  = 1'b1;
            alu_reg_d  = AluReg;
            alu_data_d = AluData;
        end else if (grant_alu_s) begin
            alu_vld_d  = 1'b0;
        end else begin
            alu_vld_d  = alu_vld_q;
        end
        if (mem_fire_s) begin
            mem_vld_d  = 1'b1;
            mem_reg_d  = MemReg;
            mem_data_d = MemData;
        end else if (grant_mem_s) begin
            mem_vld_d  = 1'b0;
        end else begin
            mem_vld_d  = mem_vld_q;
        end
    end

    // Write port next state: register 0 grants are dropped and the address/data hold
    always_comb begin
        wr_en_d   = (grant_mem_s | grant_alu_s) & (sel_reg_s != 5'd0);
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        if (wr_en_d) begin
            wr_reg_d  = sel_reg_s;
            wr_data_d = sel_data_s;
        end else begin
            wr_reg_d  = wr_reg_q;
            wr_data_d = wr_data_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            alu_vld_q  <= 1'b0;
            alu_reg_q  <= 5'd0;
            alu_data_q <= 32'd0;
            mem_vld_q  <= 1'b0;
            mem_reg_q  <= 5'd0;
            mem_data_q <= 32'd0;
            wr_en_q    <= 1'b0;
            wr_reg_q   <= 5'd0;
            wr_data_q  <= 32'd0;
        end else begin
            alu_vld_q  <= alu_vld_d;
            alu_reg_q  <= alu_reg_d;
            alu_data_q <= alu_data_d;
            mem_vld_q  <= mem_vld_d;
            mem_reg_q  <= mem_reg_d;
            mem_data_q <= mem_data_d;
            wr_en_q    <= wr_en_d;
            wr_reg_q   <= wr_reg_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign RegWrite     = wr_en_q;
    assign WriteReg     = wr_reg_q;
    assign WriteRegData = wr_data_q;
    assign Idle         = ~alu_vld_q & ~mem_vld_q & ~wr_en_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Directed self-checking bench for regfile_write_arbiter. Inputs are driven
// and outputs sampled 1 time unit after each rising edge. Expected values are
// hand-computed constants or simple order rules. The arbitration-order
// expectations follow REGFILE_WR_ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset_n;
    logic        AluValid;
    logic [4:0]  AluReg;
    logic [31:0] AluData;
    logic        AluReady;
    logic        MemValid;
    logic [4:0]  MemReg;
    logic [31:0] MemData;
    logic        MemReady;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteRegData;
    logic        Idle;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [36:0] got_q[$];
    int          cyc_q[$];

    regfile_write_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .AluValid     (AluValid),
        .AluReg       (AluReg),
        .AluData      (AluData),
        .AluReady     (AluReady),
        .MemValid     (MemValid),
        .MemReg       (MemReg),
        .MemData      (MemData),
        .MemReady     (MemReady),
        .RegWrite     (RegWrite),
        .WriteReg     (WriteReg),
        .WriteRegData (WriteRegData),
        .Idle         (Idle)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive both requesters through valid/ready handshakes and log every write
    task automatic run_stream(input int n_mem, input int n_alu, input logic [4:0] alu_base, input int want);
        int  mi;
        int  ai;
        bit  mf;
        bit  af;
        logic [31:0] mi_v;
        logic [31:0] ai_v;
        mi = 0;
        ai = 0;
        got_q.delete();
        cyc_q.delete();
        for (int c = 0; c < 60 && got_q.size() < want; c++) begin
            mi_v     = mi;
            ai_v     = ai;
            MemValid = (mi < n_mem);
            MemReg   = 5'd16 + mi_v[4:0];
            MemData  = 32'hA000_0000 + mi_v;
            AluValid = (ai < n_alu);
            AluReg   = alu_base + ai_v[4:0];
            AluData  = 32'hB000_0000 + ai_v;
            mf = MemValid && MemReady;
            af = AluValid && AluReady;
            step();
            if (mf) mi++;
            if (af) ai++;
            if (RegWrite) begin
                got_q.push_back({WriteReg, WriteRegData});
                cyc_q.push_back(c);
            end
        end
        MemValid = 1'b0;
        AluValid = 1'b0;
    endtask

    initial begin
        logic [36:0] exp_e;
        logic [31:0] k_v;
        int          n;
        reset_n  = 1'b0;
        AluValid = 1'b0;
        AluReg   = 5'd0;
        AluData  = 32'd0;
        MemValid = 1'b0;
        MemReg   = 5'd0;
        MemData  = 32'd0;

        // Reset state
        step();
        step();
        check_value("rst_alu_ready", {63'd0, AluReady}, 64'd0);
        check_value("rst_mem_ready", {63'd0, MemReady}, 64'd0);
        check_value("rst_regwrite", {63'd0, RegWrite}, 64'd0);
        check_value("rst_writereg", {59'd0, WriteReg}, 64'd0);
        check_value("rst_writedata", {32'd0, WriteRegData}, 64'd0);
        check_value("rst_idle", {63'd0, Idle}, 64'd1);
        reset_n = 1'b1;
        step();

        // Single ALU write: visible two edges after acceptance
        AluValid = 1'b1;
        AluReg   = 5'd3;
        AluData  = 32'd10;
        check_value("s1_alu_ready", {63'd0, AluReady}, 64'd1);
        step();
        AluValid = 1'b0;
        check_value("s1_no_early_write", {63'd0, RegWrite}, 64'd0);
        check_value("s1_busy", {63'd0, Idle}, 64'd0);
        step();
        check_value("s1_regwrite", {63'd0, RegWrite}, 64'd1);
        check_value("s1_writereg", {59'd0, WriteReg}, 64'd3);
        check_value("s1_writedata", {32'd0, WriteRegData}, 64'd10);
        step();
        check_value("s1_regwrite_off", {63'd0, RegWrite}, 64'd0);
        check_value("s1_idle", {63'd0, Idle}, 64'd1);
        check_value("s1_hold_reg", {59'd0, WriteReg}, 64'd3);

        // Contention: Mem wins first, Alu waits one cycle
        AluValid = 1'b1;
        AluReg   = 5'd7;
        AluData  = 32'h11;
        MemValid = 1'b1;
        MemReg   = 5'd8;
        MemData  = 32'h22;
        step();
        AluValid = 1'b0;
        MemValid = 1'b0;
        check_value("s2_alu_blocked", {63'd0, AluReady}, 64'd0);
        check_value("s2_mem_ready", {63'd0, MemReady}, 64'd1);
        step();
        check_value("s2_w1_en", {63'd0, RegWrite}, 64'd1);
        check_value("s2_w1_reg", {59'd0, WriteReg}, 64'd8);
        check_value("s2_w1_data", {32'd0, WriteRegData}, 64'h22);
        check_value("s2_alu_ready_again", {63'd0, AluReady}, 64'd1);
        step();
        check_value("s2_w2_en", {63'd0, RegWrite}, 64'd1);
        check_value("s2_w2_reg", {59'd0, WriteReg}, 64'd7);
        check_value("s2_w2_data", {32'd0, WriteRegData}, 64'h11);
        step();
        check_value("s2_idle", {63'd0, Idle}, 64'd1);

        // Both requesters streaming four entries each
        run_stream(4, 4, 5'd24, 8);
        n = got_q.size();
        check_value("s3_count", n, 64'd8);
        for (int k = 0; k < 8; k++) begin
`ifdef REGFILE_WR_ROUND_ROBIN_EN
            k_v = k / 2;
            if (k % 2 == 0) exp_e = {5'd16 + k_v[4:0], 32'hA000_0000 + k_v};
            else            exp_e = {5'd24 + k_v[4:0], 32'hB000_0000 + k_v};
`else
            k_v = (k < 4) ? k : k - 4;
            if (k < 4) exp_e = {5'd16 + k_v[4:0], 32'hA000_0000 + k_v};
            else       exp_e = {5'd24 + k_v[4:0], 32'hB000_0000 + k_v};
`endif
            if (k < n) check_value($sformatf("s3_order_%0d", k), {27'd0, got_q[k]}, {27'd0, exp_e});
            else       check_value($sformatf("s3_missing_%0d", k), 64'd0, {27'd0, exp_e});
        end

        // Register 0 load: consumed silently, write port holds previous values
        step();
        MemValid = 1'b1;
        MemReg   = 5'd0;
        MemData  = 32'hFFFF_FFFF;
        check_value("s4_mem_ready", {63'd0, MemReady}, 64'd1);
        step();
        MemValid = 1'b0;
        check_value("s4_buffered", {63'd0, Idle}, 64'd0);
        step();
        check_value("s4_no_write", {63'd0, RegWrite}, 64'd0);
        check_value("s4_hold_reg", {59'd0, WriteReg}, 64'd27);
        check_value("s4_hold_data", {32'd0, WriteRegData}, 64'hB000_0003);
        check_value("s4_idle", {63'd0, Idle}, 64'd1);
        step();
        check_value("s4_still_no_write", {63'd0, RegWrite}, 64'd0);

        // Reset while the Alu buffer holds reg 5
        AluValid = 1'b1;
        AluReg   = 5'd5;
        AluData  = 32'h55;
        step();
        AluValid = 1'b0;
        reset_n  = 1'b0;
        step();
        check_value("s5_rst_alu_ready", {63'd0, AluReady}, 64'd0);
        check_value("s5_rst_mem_ready", {63'd0, MemReady}, 64'd0);
        reset_n = 1'b1;
        check_value("s5_regwrite", {63'd0, RegWrite}, 64'd0);
        check_value("s5_writereg", {59'd0, WriteReg}, 64'd0);
        check_value("s5_writedata", {32'd0, WriteRegData}, 64'd0);
        check_value("s5_idle", {63'd0, Idle}, 64'd1);
        step();
        check_value("s5_no_late_write", {63'd0, RegWrite}, 64'd0);
        check_value("s5_idle_after", {63'd0, Idle}, 64'd1);

        // Eight back-to-back ALU writes, one per cycle
        run_stream(0, 8, 5'd1, 8);
        n = got_q.size();
        check_value("s6_count", n, 64'd8);
        for (int k = 0; k < 8; k++) begin
            k_v   = k;
            exp_e = {5'd1 + k_v[4:0], 32'hB000_0000 + k_v};
            if (k < n) check_value($sformatf("s6_order_%0d", k), {27'd0, got_q[k]}, {27'd0, exp_e});
            else       check_value($sformatf("s6_missing_%0d", k), 64'd0, {27'd0, exp_e});
        end
        if (n == 8) begin
            check_value("s6_first_latency", cyc_q[0], 64'd1);
            check_value("s6_back_to_back", cyc_q[7] - cyc_q[0], 64'd7);
        end else begin
            check_value("s6_timing", n, 64'd8);
        end
        step();
        check_value("s6_idle", {63'd0, Idle}, 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL change only on the rising edge of clk.
REQ-002 The ports SHALL be:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous active-low reset
- AluValid  in  1  ALU writeback request
- AluReg  in  5  ALU destination register
- AluData  in  32  ALU result
- AluReady  out  1  ALU request accepted this cycle when AluValid=1
- MemValid  in  1  load writeback request
- MemReg  in  5  load destination register
- MemData  in  32  load data
- MemReady  out  1  load request accepted this cycle when MemValid=1
- RegWrite  out  1  register-file write enable
- WriteReg  out  5  register-file write address
- WriteRegData  out  32  register-file write data
- Idle  out  1  both holding buffers empty and no write issuing
REQ-003 RegWrite, WriteReg and WriteRegData SHALL connect directly to the Registers_32 write port; this block is the only driver of that port.

Function
REQ-004 Each requester SHALL have a one-entry holding buffer (valid, reg[4:0], data[31:0]).
REQ-005 A transfer SHALL occur on a clock edge where Valid=1 and Ready=1; the buffer loads Reg/Data on that edge.
REQ-006 The Ready output SHALL be 1 when its buffer is empty or is granted in the current cycle; it SHALL NOT depend combinationally on Valid, Reg or Data inputs.
REQ-007 Each cycle the arbiter SHALL grant at most one valid buffer; a granted buffer empties on the edge unless refilled by a same-edge transfer.
REQ-008 Default policy (fixed priority): Mem buffer SHALL win over Alu buffer when both are valid.
REQ-009 On a grant to a nonzero register, RegWrite SHALL be 1 in the next cycle, with WriteReg/WriteRegData equal to the granted buffer contents; otherwise RegWrite SHALL be 0.
REQ-010 Latency: a request accepted at edge E with no contention SHALL produce RegWrite=1 in the cycle following edge E+1.
REQ-011 A granted entry with reg=0 SHALL be consumed (the buffer empties) without asserting RegWrite; WriteReg/WriteRegData SHALL hold their previous values.
REQ-012 When RegWrite=0, WriteReg and WriteRegData SHALL hold their last values.
REQ-013 A buffer SHALL never be overwritten while valid and not granted; a losing requester SHALL see Ready=0 until its buffer is granted.
REQ-014 Writes SHALL reach the register file in grant order; entries from the same requester SHALL stay in acceptance order.
REQ-015 Idle SHALL be 1 when both buffers are empty and RegWrite=0.

Reset
REQ-016 While reset_n=0 at an edge, both buffers SHALL clear; RegWrite=0, WriteReg=0, WriteRegData=0; the round-robin pointer (if present) SHALL point to Mem.
REQ-017 During reset, AluReady=0 and MemReady=0, and no transfer SHALL occur.
REQ-018 Reset asserted while an entry is buffered or a write is pending SHALL discard it; no RegWrite pulse SHALL follow the reset edge.

Configuration
REQ-019 Macro REGFILE_WR_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-020 Without the macro: fixed priority per REQ-008.
REQ-021 With the macro: a 1-bit pointer SHALL give priority to the requester not granted last. The pointer SHALL update only on a grant and SHALL advance on grants to register 0 as well.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Reset, then AluValid=1, AluReg=3, AluData=10 for one cycle -> RegWrite=1, WriteReg=3, WriteRegData=10 exactly two edges after acceptance, then RegWrite=0 and Idle=1.
- Alu (reg 7, 0x11) and Mem (reg 8, 0x22) valid on the same edge, macro off -> write reg 8 then reg 7 on consecutive cycles; AluReady=0 for one cycle.
- Same as above with REGFILE_WR_ROUND_ROBIN_EN and both held valid with new data every cycle -> grants alternate Mem, Alu, Mem, Alu; no entry is lost or duplicated.
- MemValid=1, MemReg=0, MemData=0xFFFFFFFF -> buffer consumed, RegWrite stays 0, WriteReg/WriteRegData unchanged.
- reset_n=0 for one edge while Alu buffer holds reg 5 -> no RegWrite afterward; all outputs 0; Idle=1.
- AluValid held high for 8 cycles with distinct data, Mem idle -> 8 consecutive RegWrite pulses in order, one per cycle after the initial latency.
